// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/NOT) between two requesters.
// Optional registered zero flag on the result when LOGIC_ZERO_FLAG_EN is defined.
module logic_unit_arbiter #(
    parameter int DATA_W = 64,
    parameter int OP_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_id
`ifdef LOGIC_ZERO_FLAG_EN
    ,
    output logic              res_zero
`endif
);

    localparam logic [OP_W-1:0] OP_AND = OP_W'(0);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(2);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic              slot_free;
    logic              grant_valid;
    logic              grant;
    logic              accept;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [DATA_W-1:0] result;

    assign res_valid = (state == FULL);
    assign slot_free = !res_valid || res_ready;

    // Grant goes to the only valid requester, or away from the last winner when both ask.
    // Ready is forced low while reset is asserted.
    always_comb begin
        grant_valid = rst_n && slot_free && (req0_valid || req1_valid);
        grant       = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else if (req1_valid)
            grant = 1'b1;
        req0_ready = grant_valid && !grant;
        req1_ready = grant_valid && grant;
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end

    always_comb begin
        sel_op = grant ? req1_op : req0_op;
        sel_a  = grant ? req1_a  : req0_a;
        sel_b  = grant ? req1_b  : req0_b;
        case (sel_op)
            OP_AND:  result = sel_a & sel_b;
            OP_OR:   result = sel_a | sel_b;
            OP_XOR:  result = sel_a ^ sel_b;
            default: result = ~sel_a;
        endcase
    end

    // FULL stays FULL on stall or drain-and-refill; it empties only on a drain with no accept.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (res_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_next;
    end

    // Result register only loads on an accept, so a drain leaves data and id untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data   <= '0;
            res_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            res_data   <= result;
            res_id     <= grant;
            last_grant <= grant;
        end
    end

`ifdef LOGIC_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            res_zero <= 1'b0;
        else if (accept)
            res_zero <= (result == '0);
    end
`endif

endmodule
